// File: rtl/rr_dec_arbiter.sv
// rr_dec_arbiter: round-robin arbiter for one shared M-to-N decoded resource.
// It drives a registered binary index (Gidx) and an active-low enable (_gen)
// for an external decoder, plus a registered one-hot grant (Gnt).
// A grant is held until the owner asserts done or drops its request.
// Optional feature: define ARB_TIMEOUT_EN to force-release a grant after
// exactly HOLD_MAX cycles.
module rr_dec_arbiter #(
  parameter int M        = 3,
  parameter int N        = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [M-1:0] Gidx,
  output logic         _gen,
  output logic [N-1:0] Gnt
);

  // Reject illegal configurations at elaboration time.
  if (N < 2 || N > (1 << M)) begin : g_bad_n
    $error("rr_dec_arbiter: N must satisfy 2 <= N <= 2**M");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("rr_dec_arbiter: HOLD_MAX must be at least 1");
  end

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]   state;
  logic [M-1:0] ptr;        // index of the most recent owner
  logic         pick_valid;
  logic [M-1:0] pick_idx;
  logic         rel;        // current grant ends at this edge

  // Round-robin pick: lowest set request above ptr wins, else lowest at or below ptr.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Wrap-around group first; a later assignment overrides an earlier one.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && i <= int'(ptr)) begin
        pick_valid = 1'b1;
        pick_idx   = M'(i);
      end
    end
    // Indices above ptr have priority over the wrap-around group.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && i > int'(ptr)) begin
        pick_valid = 1'b1;
        pick_idx   = M'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt;

  // Hold counter: zero while idle (so it is clear on grant entry), saturating count in GRANT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != CW'(HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Release on done, owner request drop, or the last allowed grant cycle.
  always_comb begin
    rel = done || !req[Gidx] || (hold_cnt == CW'(HOLD_MAX - 1));
  end
`else
  // Release on done or owner request drop; no time limit.
  always_comb begin
    rel = done || !req[Gidx];
  end
`endif

  // Arbiter FSM and registered decoder-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      Gidx  <= '0;
      _gen  <= 1'b1;
      Gnt   <= '0;
      ptr   <= M'(N - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (pick_valid) begin
            Gidx  <= pick_idx;
            Gnt   <= N'(1) << pick_idx;
            ptr   <= pick_idx;
            _gen  <= 1'b0;
            state <= GRANT;
          end
        end
        GRANT: begin
          // Gidx keeps its value so the decoder input stays stable across release.
          if (rel) begin
            _gen  <= 1'b1;
            Gnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_dec_arbiter.md
# rr_dec_arbiter

Round-robin arbiter that shares one M-to-N decoded resource among N requesters. It grants one requester at a time, drives the binary index and active-low enable that sequence an M-to-N decoder, and also provides the decoded one-hot grant. Grants are held until the owner releases them, with an optional hold timeout.

## Interface
Parameters:
- M, 3, width of the binary grant index.
- N, 8, number of requesters. Legal range is 2 ≤ N ≤ 2^M; elaboration fails otherwise.
- HOLD_MAX, 15, maximum grant length in cycles. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  request vector; bit i is requester i.
- done  input  1  current owner releases the grant; sampled only in GRANT.
- Gidx  output  M  registered binary index of the owner; drives the decoder Din.
- _gen  output  1  registered grant enable, active-low; drives the decoder _en. 0 means a grant is valid.
- Gnt  output  N  registered one-hot grant. Equals decode(Gidx) when _gen=0, otherwise all zeros.

## Operation
- Reset state:
  - state=IDLE, _gen=1, Gidx=0, Gnt=0.
  - The round-robin pointer is ptr=N-1, so the first search starts at index 0.
- IDLE:
  - If req≠0, select the first set bit scanning ptr+1, ptr+2, … with wraparound modulo N.
  - Load Gidx with that index, Gnt with its one-hot value, ptr with that index, set _gen=0, and go to GRANT.
  - If req=0, stay in IDLE with outputs unchanged from their idle values.
- GRANT: hold Gidx/Gnt/_gen. Exit to IDLE on any one of:
  - done=1;
  - req[Gidx]=0 (owner dropped its request);
  - timeout (ARB_TIMEOUT_EN only).
- On exit, _gen=1 and Gnt=0 are registered. Gidx keeps its last value.
- There is always at least one IDLE cycle between consecutive grants; this is the decoder turnaround.
- Fairness: after owner k releases, the next grant goes to the lowest set request in k+1…N-1, then 0…k. The previous owner is served again only if it is the only requester.
- Index values ≥N are never produced.
- Requests for other indices that appear or disappear during GRANT are ignored until the next IDLE evaluation.

## Timing
- Grant latency: req asserted before edge t while in IDLE → Gidx/_gen/Gnt valid after edge t (1 cycle).
- Release: done=1 or owner req low at edge t → _gen=1, Gnt=0 after edge t. The earliest next grant follows edge t+1.
- Back-to-back throughput: one grant per 2 cycles minimum, at a grant length of 1 cycle.
- done in the same cycle the grant is first presented (i.e. the first GRANT cycle) is legal and gives a 1-cycle grant.
- done asserted while in IDLE is ignored.
- Reset mid-grant: outputs go to their reset values immediately (asynchronous), and ptr returns to N-1. The owner loses the grant with no handover cycle.
- Gnt and _gen never glitch; they are registered outputs only.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A hold counter (width ceil(log2(HOLD_MAX+1))) clears on grant entry and increments each GRANT cycle.
  - When the count equals HOLD_MAX-1 at an edge, the grant is force-released. The grant therefore lasts exactly HOLD_MAX cycles.
  - The counter saturates and never wraps.
  - A forced release updates ptr identically to a normal release, so the timed-out owner goes to the back of the order.
- ARB_TIMEOUT_EN undefined:
  - No counter is built, and HOLD_MAX is unused.
  - A grant is held indefinitely until done or owner request drop.

## Test plan
- Reset: rst=1 with arbitrary req → _gen=1, Gidx=0, Gnt=8'h00. Release rst with req=8'h00 → outputs unchanged for 5 cycles.
- Single requester: req=8'h20 → one cycle later Gidx=5, Gnt=8'h20, _gen=0. Pulse done → next cycle _gen=1, Gnt=8'h00.
- Rotation: req=8'hFF held, done pulsed on every GRANT cycle → grant order 0,1,2,…,7,0. _gen alternates 0/1 each cycle.
- Fairness and wrap: owner 6 with req=8'h41 → after release, next owner is 0 (not 6). With req=8'h40 only → 6 is re-granted after one IDLE cycle.
- Release by request drop: owner 3, clear req[3] with done=0 → _gen=1 next cycle. Simultaneous done=1 and req drop → single release, no double advance.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=3): req=8'h03, done held 0 → owner 0 held exactly 3 cycles, 1 IDLE cycle, then owner 1 for 3 cycles. Assert rst in the 2nd grant cycle → immediate reset values, and the first grant after reset goes to 0.
